// File: rtl/nes_pad_responder.sv
// Device-side NES gamepad emulator: answers host latch/clock and shifts out 8 active-low button bits.
// Optional autofire on A/B is enabled by defining NES_PAD_TURBO_EN.
module nes_pad_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic        FILL_BIT       = 1'b1,
  parameter int unsigned TURBO_DIV      = 4
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       latch_in,
  input  logic       clock_in,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  if (TURBO_DIV == 0) begin : gBadTurboDiv
    $error("nes_pad_responder: TURBO_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      latchSync_q, clkSync_q;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [7:0]      snap_q, snap_d;
  logic [WD_W-1:0] wdCnt_q, wdCnt_d;
  logic            frameDone_q, frameDone_d;
  logic            timeout_q, timeout_d;

  logic       latchHigh, latchFall, clkRise;
  logic [7:0] padImage;

  // Bit 1 is the synchronised level, bit 2 the delayed copy used for edge detection.
  assign latchHigh = latchSync_q[1];
  assign latchFall = ~latchSync_q[1] & latchSync_q[2];
  assign clkRise   = clkSync_q[1] & ~clkSync_q[2];

`ifdef NES_PAD_TURBO_EN
  localparam int unsigned TC_W = (TURBO_DIV > 2) ? $clog2(TURBO_DIV) : 1;

  logic [TC_W-1:0] turboCnt_q, turboCnt_d;
  logic            turbo_q, turbo_d;

  always_comb begin
    turboCnt_d = turboCnt_q;
    turbo_d    = turbo_q;
    if (latchFall) begin
      if (turboCnt_q == TC_W'(TURBO_DIV - 1)) begin
        turboCnt_d = '0;
        turbo_d    = ~turbo_q;
      end else begin
        turboCnt_d = turboCnt_q + TC_W'(1);
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      turboCnt_q <= '0;
      turbo_q    <= 1'b0;
    end else begin
      turboCnt_q <= turboCnt_d;
      turbo_q    <= turbo_d;
    end
  end

  assign padImage = {buttons[7] & turbo_q, buttons[6] & turbo_q, buttons[5:0]};
`else
  assign padImage = buttons;
`endif

  // Latch always wins: it aborts SHIFT and masks any shift clock seen alongside it.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    snap_d      = snap_q;
    wdCnt_d     = '0;
    frameDone_d = 1'b0;
    timeout_d   = 1'b0;
    data_out    = 1'b1;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (latchHigh) state_d = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        snap_d   = ~padImage;
        data_out = ~padImage[7];
        if (latchFall) begin
          state_d  = SHIFT;
          bitCnt_d = '0;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        data_out = snap_q[3'd7 - bitCnt_q];
        if (latchHigh) begin
          state_d = LOAD;
        end else if (clkRise) begin
          if (bitCnt_q == 3'd7) begin
            state_d = DONE;
          end else begin
            bitCnt_d    = bitCnt_q + 3'd1;
            frameDone_d = (bitCnt_q == 3'd6);
          end
        end else if (wdCnt_q == WD_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wdCnt_d = wdCnt_q + WD_W'(1);
        end
      end
      DONE: begin
        data_out = FILL_BIT;
        if (latchHigh) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q     <= IDLE;
      latchSync_q <= '0;
      clkSync_q   <= '0;
      bitCnt_q    <= '0;
      snap_q      <= '0;
      wdCnt_q     <= '0;
      frameDone_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      latchSync_q <= {latchSync_q[1:0], latch_in};
      clkSync_q   <= {clkSync_q[1:0], clock_in};
      bitCnt_q    <= bitCnt_d;
      snap_q      <= snap_d;
      wdCnt_q     <= wdCnt_d;
      frameDone_q <= frameDone_d;
      timeout_q   <= timeout_d;
    end
  end

  assign frame_done = frameDone_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: full frames, extra clocks, latch abort, reset, watchdog, turbo.
module tb_nes_pad_responder;

  logic       clk48 = 1'b0;
  logic       rst;
  logic       latch_in, clock_in, wdLatch, wdClock;
  logic [7:0] buttons;
  logic       data_out, busy, frame_done, timeout;
  logic       wdData, wdBusy, wdFrameDone, wdTimeout;

  int vectors     = 0;
  int miscompares = 0;
  int fdCount     = 0;
  int toCount     = 0;
  int wdFdCount   = 0;
  int wdToCount   = 0;

  always #5 clk48 = ~clk48;

  nes_pad_responder #(.TIMEOUT_CYCLES(4096), .FILL_BIT(1'b1), .TURBO_DIV(2)) dut (
    .clk48(clk48), .rst(rst), .latch_in(latch_in), .clock_in(clock_in), .buttons(buttons),
    .data_out(data_out), .busy(busy), .frame_done(frame_done), .timeout(timeout)
  );

  nes_pad_responder #(.TIMEOUT_CYCLES(64), .FILL_BIT(1'b1), .TURBO_DIV(2)) wdDut (
    .clk48(clk48), .rst(rst), .latch_in(wdLatch), .clock_in(wdClock), .buttons(buttons),
    .data_out(wdData), .busy(wdBusy), .frame_done(wdFrameDone), .timeout(wdTimeout)
  );

  // Pulse counters let the directed sequence check "exactly once" / "never" properties.
  always @(posedge clk48) begin
    if (frame_done === 1'b1) fdCount <= fdCount + 1;
    if (timeout === 1'b1) toCount <= toCount + 1;
    if (wdFrameDone === 1'b1) wdFdCount <= wdFdCount + 1;
    if (wdTimeout === 1'b1) wdToCount <= wdToCount + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic latchLvl, input logic clockLvl, input logic [7:0] pad);
    latch_in = latchLvl;
    clock_in = clockLvl;
    buttons  = pad;
  endtask

  task automatic clockPulse();
    clock_in = 1'b1;
    tick(256);
    clock_in = 1'b0;
    tick(256);
  endtask

  task automatic latchPulse(input logic [7:0] pad);
    applyStimulus(1'b1, 1'b0, pad);
    tick(512);
    checkOutput("load busy", {31'd0, busy}, 32'd1);
    latch_in = 1'b0;
    tick(256);
  endtask

  // Samples each bit just before the next host rising edge; checks frame_done timing on the 7th edge.
  task automatic shiftFrame(input logic [7:0] expLine, input string tag);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s bit%0d", tag, i), {31'd0, data_out}, {31'd0, expLine[7-i]});
      clock_in = 1'b1;
      if (i == 6) begin
        tick(2);
        checkOutput({tag, " done early"}, {31'd0, frame_done}, 32'd0);
        tick(1);
        checkOutput({tag, " done pulse"}, {31'd0, frame_done}, 32'd1);
        tick(1);
        checkOutput({tag, " done single"}, {31'd0, frame_done}, 32'd0);
        tick(252);
      end else begin
        tick(256);
      end
      clock_in = 1'b0;
      tick(256);
    end
    checkOutput({tag, " fill"}, {31'd0, data_out}, 32'd1);
    checkOutput({tag, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] turboExp;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    wdLatch = 1'b0;
    wdClock = 1'b0;
    tick(3);
    checkOutput("reset data_out", {31'd0, data_out}, 32'd1);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("reset timeout", {31'd0, timeout}, 32'd0);
    checkOutput("reset wd data_out", {31'd0, wdData}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(10);
      checkOutput("quiet data_out", {31'd0, data_out}, 32'd1);
      checkOutput("quiet busy", {31'd0, busy}, 32'd0);
    end

    // Full frame with A and Right pressed, including live LOAD output.
    applyStimulus(1'b1, 1'b0, 8'b1000_0001);
    tick(5);
    checkOutput("load live A", {31'd0, data_out}, 32'd0);
    buttons = 8'h00;
    tick(1);
    checkOutput("load live release", {31'd0, data_out}, 32'd1);
    buttons = 8'b1000_0001;
    tick(506);
    checkOutput("load busy", {31'd0, busy}, 32'd1);
    latch_in = 1'b0;
    tick(256);
    shiftFrame(8'b0111_1110, "frame1");
    checkOutput("frame1 done count", fdCount, 32'd1);

    for (int i = 0; i < 4; i++) begin
      clockPulse();
      checkOutput("extra clock fill", {31'd0, data_out}, 32'd1);
    end
    checkOutput("extra clock done count", fdCount, 32'd1);

    // Abort after 3 clocks, then a full frame of all-pressed buttons.
    latchPulse(8'h10);
    for (int i = 0; i < 3; i++) clockPulse();
    checkOutput("abort mid Start", {31'd0, data_out}, 32'd0);
    checkOutput("abort mid busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'hFF);
    tick(512);
    checkOutput("abort no done", fdCount, 32'd1);
    checkOutput("abort in load", {31'd0, busy}, 32'd1);
    checkOutput("abort live A", {31'd0, data_out}, 32'd0);
    latch_in = 1'b0;
    tick(256);
    shiftFrame(8'h00, "refill");
    checkOutput("refill done count", fdCount, 32'd2);

    // Reset mid-frame with host lines held high.
    applyStimulus(1'b1, 1'b0, 8'h40);
    tick(10);
    latch_in = 1'b0;
    tick(10);
    clock_in = 1'b1;
    tick(10);
    clock_in = 1'b0;
    tick(10);
    checkOutput("midframe B bit", {31'd0, data_out}, 32'd0);
    checkOutput("midframe busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h40);
    tick(1);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset data_out", {31'd0, data_out}, 32'd1);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h40);
    tick(10);
    checkOutput("post reset busy", {31'd0, busy}, 32'd0);
    checkOutput("post reset done count", fdCount, 32'd2);

    // Watchdog: latch, two clocks, then silence on the 64-cycle instance.
    wdLatch = 1'b1;
    tick(10);
    wdLatch = 1'b0;
    tick(10);
    for (int i = 0; i < 2; i++) begin
      wdClock = 1'b1;
      tick(10);
      wdClock = 1'b0;
      tick(10);
    end
    checkOutput("wd shifting busy", {31'd0, wdBusy}, 32'd1);
    tick(46);
    checkOutput("wd before expiry", {31'd0, wdTimeout}, 32'd0);
    checkOutput("wd still busy", {31'd0, wdBusy}, 32'd1);
    tick(1);
    checkOutput("wd timeout pulse", {31'd0, wdTimeout}, 32'd1);
    checkOutput("wd idle busy", {31'd0, wdBusy}, 32'd0);
    checkOutput("wd idle data_out", {31'd0, wdData}, 32'd1);
    tick(100);
    checkOutput("wd timeout count", wdToCount, 32'd1);
    checkOutput("wd no frame_done", wdFdCount, 32'd0);

`ifdef NES_PAD_TURBO_EN
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    buttons  = 8'h80;
    turboExp = 8'b1100_1100;
    for (int f = 0; f < 8; f++) begin
      latch_in = 1'b1;
      tick(20);
      checkOutput($sformatf("turbo frame%0d A", f), {31'd0, data_out}, {31'd0, turboExp[7-f]});
      latch_in = 1'b0;
      tick(20);
    end
`endif

    checkOutput("main no timeout", toCount, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
